disp_frame_ctrl: RTL and testbench

Double-buffered (ping-pong) frame controller for the disparity output BRAM. It takes the SGBM disparity pixel stream (row/col tagged), steers each frame into one of two BRAM banks and checks raster order. It raises an interrupt to the PS per completed bank and holds that bank until the PS acknowledges. It drives the BRAM port directly and sits between the SGBM pipeline output and the AXI BRAM controller shared with the PS.

---
 rtl/disp_frame_if.sv | 28 ++
 rtl/disp_frame_ctrl.sv | 119 +++++++++++
 tb/tb_disp_frame_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_frame_if.sv
// disp_frame_if: pixel stream in, BRAM port and PS interrupt out for disp_frame_ctrl.
interface disp_frame_if;
    logic [31:0] disparity;
    logic [9:0]  row_in;
    logic [9:0]  col_in;
    logic        valid;
    logic        intr_ack;
    logic        ram_clk;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wr_data;
    logic        ram_rst;
    logic        intr;
    logic        done_bank;
    logic [15:0] drop_cnt;
    logic        sync_err;
    modport master (
        input  disparity, row_in, col_in, valid, intr_ack,
        output ram_clk, ram_en, ram_addr, ram_we, ram_wr_data, ram_rst,
        output intr, done_bank, drop_cnt, sync_err
    );
    modport slave (
        output disparity, row_in, col_in, valid, intr_ack,
        input  ram_clk, ram_en, ram_addr, ram_we, ram_wr_data, ram_rst,
        input  intr, done_bank, drop_cnt, sync_err
    );
endinterface

// File: rtl/disp_frame_ctrl.sv
// disp_frame_ctrl: ping-pong frame writer for the disparity BRAM with raster-order check
// and a per-bank interrupt held until the PS acknowledges.
module disp_frame_ctrl #(
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 200,
    parameter int BANK0_BASE = 0,
    parameter int BANK1_BASE = 80000
) (
    input logic clk,
    input logic rst,
    disp_frame_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
    localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);
    localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
    state_t      state, state_n;
    logic        wr_bank, wr_bank_n, rd_bank, rd_bank_n;
    logic [1:0]  full, full_n;
    logic [9:0]  row_cnt, col_cnt, row_n, col_n;
    logic [31:0] pix_cnt, pix_n, base, wr_addr;
    logic        sof, last_pix, match, wr, drop, err;
    assign bus.ram_clk = clk;
    assign base     = wr_bank ? 32'(BANK1_BASE) : 32'(BANK0_BASE);
    assign sof      = bus.valid && bus.row_in == '0 && bus.col_in == '0;
    assign last_pix = bus.row_in == LAST_ROW && bus.col_in == LAST_COL;
    assign match    = bus.row_in == row_cnt && bus.col_in == col_cnt;
    always_comb begin
        state_n   = state;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        full_n    = full;
        row_n     = row_cnt;
        col_n     = col_cnt;
        pix_n     = pix_cnt;
        wr_addr   = base + pix_cnt;
        wr        = 1'b0;
        drop      = 1'b0;
        err       = 1'b0;
        if (state == WRITE && bus.valid && match) begin
            wr    = 1'b1;
            pix_n = pix_cnt + 32'd1;
            col_n = col_cnt == LAST_COL ? '0 : col_cnt + 10'd1;
            row_n = col_cnt == LAST_COL ? row_cnt + 10'd1 : row_cnt;
            if (last_pix) begin
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = ~wr_bank;
                state_n         = IDLE;
            end
        end else if (sof) begin
            // a mismatching (0,0) in WRITE abandons the frame and restarts on the same bank
            err = state == WRITE;
            if (full[wr_bank]) begin
                drop    = 1'b1;
                state_n = DROP;
            end else begin
                wr      = 1'b1;
                wr_addr = base;
                pix_n   = 32'd1;
                col_n   = LAST_COL == '0 ? '0 : 10'd1;
                row_n   = LAST_COL == '0 ? 10'd1 : '0;
                state_n = WRITE;
            end
        end else if (bus.valid && (state == WRITE || (state == DROP && last_pix))) begin
            err     = state == WRITE;
            state_n = IDLE;
        end
        if (state_n != WRITE) begin
            pix_n = '0;
            row_n = '0;
            col_n = '0;
        end
        // ack acts on pre-update flags, so completion and ack in one cycle both land
        if (bus.intr_ack && full[rd_bank]) begin
            full_n[rd_bank] = 1'b0;
            rd_bank_n       = ~rd_bank;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            full            <= '0;
            row_cnt         <= '0;
            col_cnt         <= '0;
            pix_cnt         <= '0;
            bus.ram_en      <= 1'b0;
            bus.ram_we      <= '0;
            bus.ram_addr    <= '0;
            bus.ram_wr_data <= '0;
            bus.ram_rst     <= 1'b1;
            bus.intr        <= 1'b0;
            bus.done_bank   <= 1'b0;
            bus.drop_cnt    <= '0;
            bus.sync_err    <= 1'b0;
        end else begin
            state         <= state_n;
            wr_bank       <= wr_bank_n;
            rd_bank       <= rd_bank_n;
            full          <= full_n;
            row_cnt       <= row_n;
            col_cnt       <= col_n;
            pix_cnt       <= pix_n;
            bus.ram_en    <= wr;
            bus.ram_we    <= wr ? 4'hF : 4'h0;
            bus.ram_rst   <= 1'b0;
            bus.intr      <= |full;
            bus.done_bank <= rd_bank;
            if (wr) begin
                bus.ram_addr    <= wr_addr;
                bus.ram_wr_data <= bus.disparity;
            end
            if (drop && bus.drop_cnt != 16'hFFFF)
                bus.drop_cnt <= bus.drop_cnt + 16'd1;
            if (err)
                bus.sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_disp_frame_ctrl.sv
// tb_disp_frame_ctrl: randomized frames, acks and broken rasters against a frame-level
// bank/queue model of the ping-pong controller.
module tb_disp_frame_ctrl;
    localparam int W = 4, H = 2, B0 = 0, B1 = 16, N = W * H;
    logic clk = 1'b0, rst = 1'b1, vprev = 1'b0;
    int total = 0, bad = 0, proto_bad = 0;
    logic [31:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$];
    bit m_full[2];
    bit m_wr, m_rd, m_err;
    int m_drop;
    disp_frame_if bus();
    disp_frame_ctrl #(.IMG_W(W), .IMG_H(H), .BANK0_BASE(B0), .BANK1_BASE(B1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) vprev <= bus.valid;
    // every write must follow a valid cycle and carry full byte enables
    always @(negedge clk) if (!rst) begin
        if (bus.ram_en === 1'b1) begin
            obs_a.push_back(bus.ram_addr);
            obs_d.push_back(bus.ram_wr_data);
            if (vprev !== 1'b1) proto_bad++;
        end
        if (bus.ram_we !== (bus.ram_en === 1'b1 ? 4'hF : 4'h0)) proto_bad++;
    end

    function automatic logic [31:0] base(bit b);
        return b ? B1 : B0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int r, input int c, input logic [31:0] d, input bit ack = 1'b0);
        bus.valid = 1'b1;
        bus.row_in = 10'(r);
        bus.col_in = 10'(c);
        bus.disparity = d;
        bus.intr_ack = ack;
        tick();
        bus.valid = 1'b0;
        bus.intr_ack = 1'b0;
        bus.row_in = 10'($urandom);
        bus.col_in = 10'($urandom);
        bus.disparity = $urandom;
    endtask

    task automatic model_ack();
        if (m_full[m_rd]) begin
            m_full[m_rd] = 1'b0;
            m_rd = ~m_rd;
        end
    endtask

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0; m_wr = 0; m_rd = 0; m_err = 0; m_drop = 0;
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic ack_pulse();
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        model_ack();
    endtask

    task automatic send_frame(input int gmax, input bit ack_last = 1'b0);
        logic [31:0] d;
        bit take;
        take = !m_full[m_wr];
        for (int i = 0; i < N; i++) begin
            d = $urandom;
            if (take) begin
                exp_a.push_back(base(m_wr) + 32'(i));
                exp_d.push_back(d);
            end
            pix(i / W, i % W, d, ack_last && i == N - 1);
            if (i != N - 1) gap($urandom_range(0, gmax));
        end
        if (take) begin
            m_full[m_wr] = 1'b1;
            m_wr = ~m_wr;
        end else m_drop++;
        if (ack_last) model_ack();
    endtask

    task automatic send_broken(input int k);
        logic [31:0] d;
        bit take;
        take = !m_full[m_wr];
        for (int i = 0; i < k; i++) begin
            d = $urandom;
            if (take) begin
                exp_a.push_back(base(m_wr) + 32'(i));
                exp_d.push_back(d);
            end
            pix(i / W, i % W, d);
        end
        pix(k / W, 7, $urandom);
        if (take) m_err = 1'b1;
        else m_drop++;
    endtask

    task automatic test_reset();
        bus.valid = 0; bus.intr_ack = 0; bus.row_in = 0; bus.col_in = 0; bus.disparity = 0;
        rst = 1'b1;
        gap(2);
        total++;
        if (bus.ram_en !== 1'b0 || bus.ram_we !== 4'h0) begin
            bad++; $display("FAIL reset_en: got en=%b we=%h expected 0/0", bus.ram_en, bus.ram_we);
        end
        total++;
        if (bus.ram_addr !== 32'd0 || bus.ram_wr_data !== 32'd0) begin
            bad++; $display("FAIL reset_addr: got %h/%h expected 0/0", bus.ram_addr, bus.ram_wr_data);
        end
        total++;
        if (bus.ram_rst !== 1'b1) begin bad++; $display("FAIL reset_ram_rst: got %b expected 1", bus.ram_rst); end
        total++;
        if (bus.intr !== 1'b0 || bus.done_bank !== 1'b0 || bus.drop_cnt !== 16'd0 || bus.sync_err !== 1'b0) begin
            bad++; $display("FAIL reset_status: got intr=%b done=%b drop=%0d err=%b expected 0", bus.intr, bus.done_bank, bus.drop_cnt, bus.sync_err);
        end
        total++;
        if (bus.ram_clk !== clk) begin bad++; $display("FAIL ram_clk: got %b expected %b", bus.ram_clk, clk); end
        rst = 1'b0;
        tick();
        total++;
        if (bus.ram_rst !== 1'b0) begin bad++; $display("FAIL ram_rst_release: got %b expected 0", bus.ram_rst); end
        model_reset();
    endtask

    task automatic test_single_frame();
        send_frame(0);
        tick();
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== 1'b0) begin
            bad++; $display("FAIL single_intr: got intr=%b done=%b expected 1/0", bus.intr, bus.done_bank);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL single_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL single_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_double_buffer();
        send_frame(2);
        gap(2);
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== 1'b0) begin
            bad++; $display("FAIL double_hold: got intr=%b done=%b expected 1/0", bus.intr, bus.done_bank);
        end
        ack_pulse();
        gap(2);
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== 1'b1) begin
            bad++; $display("FAIL double_ack1: got intr=%b done=%b expected 1/1", bus.intr, bus.done_bank);
        end
        ack_pulse();
        gap(2);
        total++;
        if (bus.intr !== 1'b0) begin bad++; $display("FAIL double_ack2: got intr=%b expected 0", bus.intr); end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL double_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL double_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_drop();
        send_frame(1);
        send_frame(1);
        send_frame(1);
        gap(2);
        total++;
        if (bus.drop_cnt !== 16'(m_drop) || m_drop != 1) begin
            bad++; $display("FAIL drop_cnt: got %0d expected 1", bus.drop_cnt);
        end
        ack_pulse();
        send_frame(0);
        gap(2);
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== m_rd) begin
            bad++; $display("FAIL drop_intr: got intr=%b done=%b expected 1/%b", bus.intr, bus.done_bank, m_rd);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL drop_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL drop_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_sync_err();
        logic [31:0] d0, d1;
        ack_pulse();
        ack_pulse();
        d0 = $urandom; d1 = $urandom;
        exp_a.push_back(base(m_wr)); exp_d.push_back(d0);
        exp_a.push_back(base(m_wr) + 1); exp_d.push_back(d1);
        pix(0, 0, d0);
        pix(0, 1, d1);
        pix(0, 3, $urandom);
        m_err = 1'b1;
        gap(2);
        total++;
        if (bus.sync_err !== 1'b1 || bus.intr !== 1'b0) begin
            bad++; $display("FAIL sync_flag: got err=%b intr=%b expected 1/0", bus.sync_err, bus.intr);
        end
        send_frame(1);
        gap(2);
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== m_rd) begin
            bad++; $display("FAIL sync_recover: got intr=%b done=%b expected 1/%b", bus.intr, bus.done_bank, m_rd);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL sync_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL sync_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_ack_collision();
        bit other;
        ack_pulse();
        ack_pulse();
        send_frame(1);
        other = m_wr;
        send_frame(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.intr !== 1'b1) begin bad++; $display("FAIL collide_intr%0d: got %b expected 1", i, bus.intr); end
            tick();
        end
        total++;
        if (bus.done_bank !== other || m_rd != other) begin
            bad++; $display("FAIL collide_done: got %b expected %b", bus.done_bank, other);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL collide_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL collide_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) pix(1, $urandom_range(0, W - 1), $urandom);
            if (op <= 1) send_frame($urandom_range(0, 2));
            else if (op == 2) ack_pulse();
            else send_broken($urandom_range(1, N - 1));
            gap(2);
            total++;
            if (bus.intr !== (m_full[0] | m_full[1]) || bus.drop_cnt !== 16'(m_drop) || bus.sync_err !== m_err) begin
                bad++; $display("FAIL rand%0d_status: got intr=%b drop=%0d err=%b expected %b/%0d/%b", it, bus.intr, bus.drop_cnt, bus.sync_err, m_full[0] | m_full[1], m_drop, m_err);
            end
            total++;
            if ((m_full[0] | m_full[1]) && bus.done_bank !== m_rd) begin
                bad++; $display("FAIL rand%0d_done: got %b expected %b", it, bus.done_bank, m_rd);
            end
            total++;
            if (obs_a.size() != exp_a.size()) begin
                bad++; $display("FAIL rand%0d_writes: got %0d writes expected %0d", it, obs_a.size(), exp_a.size());
            end else foreach (exp_a[i]) begin
                total++;
                if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                    bad++; $display("FAIL rand%0d_wr%0d: got %h/%h expected %h/%h", it, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
                end
            end
            obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
        end
        total++;
        if (proto_bad != 0) begin bad++; $display("FAIL write_protocol: got %0d violations expected 0", proto_bad); end
    endtask

    task automatic test_reset_midframe();
        repeat (2) ack_pulse();
        for (int i = 0; i < 5; i++) pix(i / W, i % W, $urandom);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.ram_en !== 1'b0 || bus.ram_we !== 4'h0 || bus.ram_addr !== 32'd0 || bus.ram_rst !== 1'b1) begin
            bad++; $display("FAIL midrst_ram: got en=%b we=%h addr=%h rst=%b expected 0/0/0/1", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_rst);
        end
        total++;
        if (bus.intr !== 1'b0 || bus.sync_err !== 1'b0 || bus.drop_cnt !== 16'd0) begin
            bad++; $display("FAIL midrst_status: got intr=%b err=%b drop=%0d expected 0", bus.intr, bus.sync_err, bus.drop_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        send_frame(1);
        tick();
        total++;
        if (bus.intr !== 1'b1 || bus.done_bank !== 1'b0) begin
            bad++; $display("FAIL midrst_intr: got intr=%b done=%b expected 1/0", bus.intr, bus.done_bank);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL midrst_writes: got %0d writes expected %0d", obs_a.size(), exp_a.size());
        end else foreach (exp_a[i]) begin
            total++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                bad++; $display("FAIL midrst_wr%0d: got %h/%h expected %h/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_double_buffer();
        test_drop();
        test_sync_err();
        test_ack_collision();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
